// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop decoding with 3-sample majority vote.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchronizer on RX_IN (+2 cycles latency).
module uart_rx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int unsigned PW   = PRESCALE_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned BC_W = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ec_q, ec_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [PW-1:0]   p_q;
  logic            par_en_q, par_typ_q;
  logic            par_bad_q, par_bad_d;
  logic            s0_q, s1_q;
  logic [DW-1:0]   p_data_d;
  logic            data_valid_d, par_err_d, stp_err_d;
  logic            latch_c;
  logic            rx;
  logic            vote_c;
  logic [PW-1:0]   half_c;
  logic [PW-1:0]   p_sel_c;
  logic            vote_at_c, bit_end_c;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer, idles high like the line
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RX_IN};
  end
  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  assign p_sel_c   = (PRESCALE == PW'(16) || PRESCALE == PW'(32)) ? PRESCALE : PW'(8);
  assign half_c    = p_q >> 1;
  assign vote_c    = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
  assign vote_at_c = (ec_q == half_c + PW'(1));
  assign bit_end_c = (ec_q == p_q - PW'(1));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath updates; the falling-edge cycle itself counts as edge 0 of the start bit
  always_comb begin
    state_d      = state_q;
    ec_d         = bit_end_c ? '0 : ec_q + PW'(1);
    bc_d         = bc_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    p_data_d     = P_DATA;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    latch_c      = 1'b0;
    case (state_q)
      IDLE: begin
        ec_d = '0;
        if (!rx) begin
          state_d   = START;
          ec_d      = PW'(1);
          bc_d      = '0;
          par_bad_d = 1'b0;
          latch_c   = 1'b1;
        end
      end
      START: begin
        if (vote_at_c && vote_c) begin
          state_d = IDLE;
          ec_d    = '0;
        end else if (bit_end_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote_at_c) shift_d = {vote_c, shift_q[DW-1:1]};
        if (bit_end_c) begin
          if (bc_q == BC_W'(DW - 1)) begin
            bc_d    = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bc_d = bc_q + BC_W'(1);
          end
        end
      end
      PARITY: begin
        if (vote_at_c) par_bad_d = vote_c ^ (^shift_q) ^ par_typ_q;
        if (bit_end_c) state_d = STOP;
      end
      STOP: begin
        // Leave on the vote so a start bit right after the stop bit is caught
        if (vote_at_c) begin
          state_d   = IDLE;
          ec_d      = '0;
          stp_err_d = ~vote_c;
          par_err_d = par_bad_q;
          par_bad_d = 1'b0;
          if (vote_c && !par_bad_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ec_d    = '0;
      end
    endcase
  end

  // Datapath, sample and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ec_q       <= '0;
      bc_q       <= '0;
      shift_q    <= '0;
      p_q        <= PW'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      ec_q       <= ec_d;
      bc_q       <= bc_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      P_DATA     <= p_data_d;
      DATA_VALID <= data_valid_d;
      PAR_ERR    <= par_err_d;
      STP_ERR    <= stp_err_d;
      if (latch_c) begin
        p_q       <= p_sel_c;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
      if (state_q != IDLE && ec_q == half_c - PW'(1)) s0_q <= rx;
      if (state_q != IDLE && ec_q == half_c)          s1_q <= rx;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (default build, no input synchronizer).
module tb_uart_rx;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_pdata;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .PRESCALE(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
    .DATA_VALID(data_valid), .PAR_ERR(par_err), .STP_ERR(stp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one frame cycle by cycle (cycle 0 = start bit begins) and score its strobes.
  // p: expected ratio, pv: value driven on PRESCALE in cycle 0; config is scrambled afterwards.
  task automatic send_frame(input string tag, input logic [7:0] data, input int p,
                            input logic [PW-1:0] pv, input logic pen, input logic ptyp,
                            input logic pflip, input logic stop, input logic glitch,
                            input int idle_after, input int rst_at);
    int            k, nbits, total, exp_c;
    int            dv_n, pe_n, se_n, dv_c, pe_c, se_c;
    logic [15:0]   frame;
    logic [DW-1:0] dv_data;
    logic          perr, good;
    k     = 1 + DW + (pen ? 1 : 0);
    nbits = k + 1;
    total = nbits * p + idle_after;
    exp_c = k * p + p / 2 + 2;
    frame = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < DW; i++) frame[1 + i] = data[i];
    if (pen) frame[1 + DW] = (^data) ^ ptyp ^ pflip;
    frame[k] = stop;
    perr = pen & pflip;
    good = stop & ~perr & (rst_at < 0);
    dv_n = 0; pe_n = 0; se_n = 0; dv_c = -1; pe_c = -1; se_c = -1;
    dv_data = '0;
    for (int c = 0; c < total; c++) begin
      int   b;
      logic v;
      b = c / p;
      v = (b < nbits) ? frame[b] : 1'b1;
      if (glitch && b < nbits && (c % p) == p / 2) v = ~v;
      if (rst_at >= 0 && c > rst_at) v = 1'b1;
      rx_in    = v;
      prescale = (c == 0) ? pv : PW'(13);
      par_en   = (c == 0) ? pen : ~pen;
      par_typ  = (c == 0) ? ptyp : ~ptyp;
      rst      = (rst_at >= 0 && (c == rst_at || c == rst_at + 1));
      if (data_valid) begin dv_n++; dv_c = c; dv_data = p_data; end
      if (par_err) begin pe_n++; pe_c = c; end
      if (stp_err) begin se_n++; se_c = c; end
      if (rst_at >= 0 && c == rst_at + 1) begin
        check({tag, "/rst_pdata"}, 32'(p_data), 32'h0);
        check({tag, "/rst_flags"}, 32'({data_valid, par_err, stp_err}), 32'h0);
        exp_pdata = '0;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    check({tag, "/dv_count"}, dv_n, good ? 1 : 0);
    check({tag, "/pe_count"}, pe_n, (perr && rst_at < 0) ? 1 : 0);
    check({tag, "/se_count"}, se_n, (!stop && rst_at < 0) ? 1 : 0);
    if (good) begin
      check({tag, "/dv_cycle"}, dv_c, exp_c);
      check({tag, "/dv_data"}, 32'(dv_data), 32'(data));
      exp_pdata = data;
    end
    if (perr && rst_at < 0) check({tag, "/pe_cycle"}, pe_c, exp_c);
    if (!stop && rst_at < 0) check({tag, "/se_cycle"}, se_c, exp_c);
    check({tag, "/pdata_hold"}, 32'(p_data), 32'(exp_pdata));
  endtask

  initial begin
    int strobes;
    rst = 1'b1; rx_in = 1'b1; prescale = PW'(8); par_en = 1'b0; par_typ = 1'b0;
    exp_pdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/pdata", 32'(p_data), 32'h0);
    check("reset/dv", 32'(data_valid), 32'h0);
    check("reset/pe", 32'(par_err), 32'h0);
    check("reset/se", 32'(stp_err), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //          tag        data   p   pv         pen   ptyp  flip  stop  gl    idle rst
    send_frame("8n1_a5",   8'hA5, 8,  PW'(8),  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4,  -1);
    send_frame("p16_ok",   8'h3C, 16, PW'(16), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4,  -1);
    send_frame("p16_perr", 8'h3C, 16, PW'(16), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4,  -1);
    send_frame("a5_again", 8'h5A, 8,  PW'(8),  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4,  -1);
    send_frame("stop_err", 8'h55, 8,  PW'(8),  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, -1);
    send_frame("both_err", 8'h0F, 8,  PW'(8),  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16, -1);

    // Two-cycle low glitch on an idle line must not produce a frame
    strobes = 0;
    prescale = PW'(8);
    for (int c = 0; c < 16; c++) begin
      rx_in = (c < 2) ? 1'b0 : 1'b1;
      if (data_valid || par_err || stp_err) strobes++;
      @(posedge clk); #1;
    end
    check("glitch/strobes", strobes, 0);
    send_frame("after_gl", 8'h12, 8,  PW'(8),  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4,  -1);

    // Back-to-back odd-parity frames with a mid-bit glitch on every bit
    send_frame("b2b_01",   8'h01, 32, PW'(32), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0,  -1);
    send_frame("b2b_fe",   8'hFE, 32, PW'(32), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0,  -1);
    send_frame("b2b_80",   8'h80, 32, PW'(32), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4,  -1);

    send_frame("ps_illeg", 8'h3A, 8,  PW'(10), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4,  -1);
    send_frame("rst_mid",  8'h99, 8,  PW'(8),  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,  40);
    send_frame("after_rs", 8'hC3, 8,  PW'(8),  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4,  -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
